// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection.
// Captures decoder control and operands, resolves the write-back register,
// inserts a single bubble on a load-use dependency and counts those bubbles.
module id_ex_stage #(
  parameter logic [4:0] RA_REG = 5'd31,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_pc4,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm,
  input  logic [5:0]       id_alu_ctrl,
  input  logic             id_s_b,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic [1:0]       id_s_num_write,
  input  logic [1:0]       id_s_data_write,
  output logic             stall,
  output logic             ex_valid,
  output logic [31:0]      ex_pc4,
  output logic [31:0]      ex_rs_data,
  output logic [31:0]      ex_rt_data,
  output logic [31:0]      ex_imm,
  output logic [5:0]       ex_alu_ctrl,
  output logic             ex_s_b,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic [1:0]       ex_s_data_write,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_dst,
  output logic [CNT_W-1:0] stall_count
);

  // An all-zero EX entry is a bubble: no valid instruction, no writes.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [5:0]  alu_ctrl;
    logic        s_b;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  s_data_write;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
  } ex_t;

  ex_t        ex_q;
  logic [4:0] id_dst;
  logic       hz;
  logic       cnt_sat;

  // Opcode and shamt/funct bits are not needed here; the decoder owns them.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{id_instr[31:26], id_instr[10:0]};

  // Write-back register number selected by the decoder.
  always_comb begin
    id_dst = 5'd0;
    case (id_s_num_write)
      2'b00:   id_dst = id_instr[20:16];
      2'b01:   id_dst = id_instr[15:11];
      2'b10:   id_dst = RA_REG;
      default: id_dst = 5'd0;
    endcase
  end

  // Load in EX whose destination feeds the ID instruction; rt is compared
  // even when the ID instruction does not read it (conservative).
  assign hz = ex_q.valid & ex_q.reg_write & (ex_q.s_data_write == 2'b01)
            & (ex_q.dst != 5'd0)
            & ((ex_q.dst == id_instr[25:21]) | (ex_q.dst == id_instr[20:16]))
            & id_valid;

  // A flush kills the ID instruction, so its hazard is moot; reset masks all.
  assign stall = ~reset & (hold | (hz & ~flush));

  assign cnt_sat = &stall_count;

  // Pipeline register and bubble counter, priority reset > flush > hold > hz > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      stall_count <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (hold) begin
      ex_q <= ex_q;
    end else if (hz) begin
      ex_q <= '0;
      if (!cnt_sat) stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ex_q.valid        <= id_valid;
      ex_q.pc4          <= id_pc4;
      ex_q.rs_data      <= id_rs_data;
      ex_q.rt_data      <= id_rt_data;
      ex_q.imm          <= id_imm;
      ex_q.alu_ctrl     <= id_alu_ctrl;
      ex_q.s_b          <= id_s_b;
      ex_q.mem_write    <= id_mem_write;
      ex_q.reg_write    <= id_reg_write;
      ex_q.s_data_write <= id_s_data_write;
      ex_q.rs           <= id_instr[25:21];
      ex_q.rt           <= id_instr[20:16];
      ex_q.dst          <= id_dst;
    end
  end

  assign ex_valid        = ex_q.valid;
  assign ex_pc4          = ex_q.pc4;
  assign ex_rs_data      = ex_q.rs_data;
  assign ex_rt_data      = ex_q.rt_data;
  assign ex_imm          = ex_q.imm;
  assign ex_alu_ctrl     = ex_q.alu_ctrl;
  assign ex_s_b          = ex_q.s_b;
  assign ex_mem_write    = ex_q.mem_write;
  assign ex_reg_write    = ex_q.reg_write;
  assign ex_s_data_write = ex_q.s_data_write;
  assign ex_rs           = ex_q.rs;
  assign ex_rt           = ex_q.rt;
  assign ex_dst          = ex_q.dst;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// compared against a behavioural model of the EX slot and bubble counter.
module tb_id_ex_stage;

  localparam logic [5:0] ADDU_OP = 6'h21;
  localparam logic [5:0] ADD_OP  = 6'h20;
  localparam logic [5:0] ORI_OP  = 6'h0d;

  logic        clk = 1'b0;
  logic        reset, flush, hold, id_valid;
  logic [31:0] id_instr, id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [5:0]  id_alu_ctrl;
  logic        id_s_b, id_mem_write, id_reg_write;
  logic [1:0]  id_s_num_write, id_s_data_write;

  logic        stall, ex_valid, ex_s_b, ex_mem_write, ex_reg_write;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [5:0]  ex_alu_ctrl;
  logic [1:0]  ex_s_data_write;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [15:0] stall_count;

  // Narrow-counter instance so saturation is reachable in a short run.
  logic        s_stall, s_ex_valid, s_ex_s_b, s_ex_mem_write, s_ex_reg_write;
  logic [31:0] s_ex_pc4, s_ex_rs_data, s_ex_rt_data, s_ex_imm;
  logic [5:0]  s_ex_alu_ctrl;
  logic [1:0]  s_ex_s_data_write;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_dst;
  logic [3:0]  s_stall_count;

  id_ex_stage #(.RA_REG(5'd31), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alu_ctrl(id_alu_ctrl), .id_s_b(id_s_b), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_s_num_write(id_s_num_write), .id_s_data_write(id_s_data_write),
    .stall(stall), .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_alu_ctrl(ex_alu_ctrl), .ex_s_b(ex_s_b),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_s_data_write(ex_s_data_write),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .stall_count(stall_count)
  );

  id_ex_stage #(.RA_REG(5'd31), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alu_ctrl(id_alu_ctrl), .id_s_b(id_s_b), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_s_num_write(id_s_num_write), .id_s_data_write(id_s_data_write),
    .stall(s_stall), .ex_valid(s_ex_valid), .ex_pc4(s_ex_pc4), .ex_rs_data(s_ex_rs_data),
    .ex_rt_data(s_ex_rt_data), .ex_imm(s_ex_imm), .ex_alu_ctrl(s_ex_alu_ctrl), .ex_s_b(s_ex_s_b),
    .ex_mem_write(s_ex_mem_write), .ex_reg_write(s_ex_reg_write),
    .ex_s_data_write(s_ex_s_data_write), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_dst(s_ex_dst),
    .stall_count(s_stall_count)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Expected contents of the EX slot
  typedef struct {
    logic        v;
    logic [31:0] pc4, rs_d, rt_d, imm;
    logic [5:0]  alu;
    logic        sb, mw, rw;
    logic [1:0]  sdw;
    logic [4:0]  rs, rt, dst;
  } ex_m_t;

  ex_m_t m;
  int    bubbles;
  int    n_chk  = 0;
  int    n_pass = 0;
  logic  last_stall;
  logic  exp_hz;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h21};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  function automatic logic [4:0] dst_of(input logic [1:0] snw, input logic [31:0] ins);
    if (snw == 2'b00) return ins[20:16];
    if (snw == 2'b01) return ins[15:11];
    if (snw == 2'b10) return 5'd31;
    return 5'd0;
  endfunction

  task automatic set_id(input logic v, input logic [31:0] ins, input logic [5:0] alu,
                        input logic [1:0] snw, input logic [1:0] sdw,
                        input logic rw, input logic mw);
    id_valid = v; id_instr = ins; id_alu_ctrl = alu;
    id_s_num_write = snw; id_s_data_write = sdw;
    id_reg_write = rw; id_mem_write = mw;
    id_s_b = 1'($urandom_range(0, 1));
    id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
  endtask

  task automatic do_lw(input logic [4:0] rt);
    set_id(1'b1, i_type(6'h23, 5'd1, rt), ADD_OP, 2'b00, 2'b01, 1'b1, 1'b0);
  endtask

  task automatic do_addu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    set_id(1'b1, r_type(rs, rt, rd), ADDU_OP, 2'b01, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic check_ex();
    int sat16, sat4;
    sat16 = (bubbles > 65535) ? 65535 : bubbles;
    sat4  = (bubbles > 15) ? 15 : bubbles;
    chk("ex_valid", ex_valid, m.v);
    chk("ex_pc4", ex_pc4, m.pc4);
    chk("ex_rs_data", ex_rs_data, m.rs_d);
    chk("ex_rt_data", ex_rt_data, m.rt_d);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_alu_ctrl", ex_alu_ctrl, m.alu);
    chk("ex_ctrl", {ex_s_b, ex_mem_write, ex_reg_write, ex_s_data_write},
        {m.sb, m.mw, m.rw, m.sdw});
    chk("ex_regs", {ex_rs, ex_rt, ex_dst}, {m.rs, m.rt, m.dst});
    chk("stall_count", stall_count, 64'(sat16));
    chk("small_count", s_stall_count, 64'(sat4));
    chk("small_dst", s_ex_dst, m.dst);
  endtask

  // One clock: check stall mid-cycle, advance the model on the edge, check EX.
  task automatic step();
    logic exp_stall;
    #3;
    exp_hz = m.v && m.rw && m.sdw == 2'b01 && m.dst != 5'd0 &&
             (m.dst == id_instr[25:21] || m.dst == id_instr[20:16]) && id_valid;
    exp_stall = !reset && (hold || (exp_hz && !flush));
    last_stall = stall;
    chk("stall", stall, exp_stall);
    chk("small_stall", s_stall, exp_stall);
    @(posedge clk);
    if (reset) begin
      m = '{default: '0};
      bubbles = 0;
    end else if (flush) begin
      m = '{default: '0};
    end else if (hold) begin
      m = m;
    end else if (exp_hz) begin
      m = '{default: '0};
      bubbles++;
    end else begin
      m.v = id_valid; m.pc4 = id_pc4; m.rs_d = id_rs_data; m.rt_d = id_rt_data;
      m.imm = id_imm; m.alu = id_alu_ctrl; m.sb = id_s_b; m.mw = id_mem_write;
      m.rw = id_reg_write; m.sdw = id_s_data_write;
      m.rs = id_instr[25:21]; m.rt = id_instr[20:16];
      m.dst = dst_of(id_s_num_write, id_instr);
    end
    #1;
    check_ex();
  endtask

  initial begin
    logic [4:0] pick [4] = '{5'd0, 5'd5, 5'd7, 5'd9};
    logic [4:0] ra, rb, rc;
    int kind;
    m = '{default: '0};
    bubbles = 0;
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    set_id(1'b0, 32'd0, 6'd0, 2'b00, 2'b00, 1'b0, 1'b0);

    // 1: reset, then addu rd=3
    repeat (3) step();
    chk("t1_rst_valid", ex_valid, 1'b0);
    chk("t1_rst_count", stall_count, 16'd0);
    chk("t1_rst_stall", last_stall, 1'b0);
    reset = 1'b0;
    do_addu(5'd1, 5'd2, 5'd3);
    step();
    chk("t1_dst", ex_dst, 5'd3);
    chk("t1_alu", ex_alu_ctrl, ADDU_OP);
    chk("t1_rw", ex_reg_write, 1'b1);

    // 2: load-use on rs costs one bubble
    do_lw(5'd5); step();
    do_addu(5'd5, 5'd2, 5'd4); step();
    chk("t2_stall", last_stall, 1'b1);
    chk("t2_bubble", ex_valid, 1'b0);
    chk("t2_count", stall_count, 16'd1);
    step();
    chk("t2_nostall", last_stall, 1'b0);
    chk("t2_addu_in", ex_dst, 5'd4);

    // 3: $0 never hazards; rt-only use of a load still does
    do_lw(5'd0); step();
    do_addu(5'd0, 5'd0, 5'd6); step();
    chk("t3_zero_nostall", last_stall, 1'b0);
    chk("t3_zero_valid", ex_valid, 1'b1);
    do_lw(5'd5); step();
    do_addu(5'd1, 5'd5, 5'd6); step();
    chk("t3_rt_stall", last_stall, 1'b1);
    chk("t3_rt_count", stall_count, 16'd2);
    step();

    // 4: hazard killed by flush
    do_lw(5'd5); step();
    do_addu(5'd5, 5'd5, 5'd8); flush = 1'b1; step(); flush = 1'b0;
    chk("t4_stall", last_stall, 1'b0);
    chk("t4_bubble", ex_valid, 1'b0);
    chk("t4_count", stall_count, 16'd2);

    // 5: hold freezes an ori, then flush under hold bubbles
    set_id(1'b1, i_type(ORI_OP, 5'd2, 5'd11), ORI_OP, 2'b00, 2'b00, 1'b1, 1'b0);
    step();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_addu(5'd3, 5'd4, 5'd12);
      step();
      chk("t5_hold_dst", ex_dst, 5'd11);
      chk("t5_hold_stall", last_stall, 1'b1);
    end
    flush = 1'b1; step(); flush = 1'b0; hold = 1'b0;
    chk("t5_flush_bubble", ex_valid, 1'b0);

    // 6: jal destination, then counter saturation on the narrow instance
    set_id(1'b1, {6'h03, 26'h0000123}, ADD_OP, 2'b10, 2'b10, 1'b1, 1'b0);
    step();
    chk("t6_jal_dst", ex_dst, 5'd31);
    chk("t6_jal_sdw", ex_s_data_write, 2'b10);
    for (int i = 0; i < 19; i++) begin
      do_lw(5'd7); step();
      do_addu(5'd7, 5'd1, 5'd2); step();
    end
    chk("t6_small_sat", s_stall_count, 4'hF);
    chk("t6_wide_count", stall_count, 16'(bubbles));

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      ra = pick[$urandom_range(0, 3)];
      rb = pick[$urandom_range(0, 3)];
      rc = pick[$urandom_range(0, 3)];
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1: do_lw(rb);
        2: do_addu(ra, rb, rc);
        3: set_id(1'b1, {6'h03, 26'(ra)}, ADD_OP, 2'b10, 2'b10, 1'b1, 1'b0);
        default: set_id(1'b1, r_type(ra, rb, rc), 6'($urandom), 2'($urandom),
                        2'($urandom), 1'($urandom), 1'($urandom));
      endcase
      id_valid = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
